pi_route_defl: RTL and testbench

Registered, parametrised successor to the lean pi-switch router for the deflection NoC. It accepts up to four packets per cycle on ports L, R, U0 and U1, routes each towards its destination, and resolves conflicts by deflection. Deflection is bufferless: every valid input always leaves on some output. The block carries the full address and data payload, sets the deflection flag it generates, prioritises previously deflected packets, rotates fairness priority, and keeps a saturating deflection counter.

---
 rtl/pi_route_defl.sv | 198 +++++++++++++++++++
 tb/tb_pi_route_defl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pi_route_defl.sv
// pi_route_defl
// Registered deflection-routing pi-switch for a tree NoC. Up to four packets
// arrive per cycle on L, R, U0 and U1. Each packet is routed towards its
// destination. Conflicts are resolved by deflection, so every valid input
// always leaves on some output one cycle later.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   ce                  clock enable; all state frozen when low
//   {l,r,u0,u1}_i_*     input valid / upstream-deflected flag / address / payload
//   {l,r,u0,u1}_o_*     registered valid / deflected-here flag / address / payload
//   defl_cnt            saturating count of deflections made by this switch
module pi_route_defl #(
  parameter int N     = 8,
  parameter int A_W   = $clog2(N) + 1,
  parameter int D_W   = 32,
  parameter int posl  = 0,
  parameter int posx  = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             l_i_v,
  input  logic             l_i_defl,
  input  logic [A_W-1:0]   l_i_addr,
  input  logic [D_W-1:0]   l_i_data,
  input  logic             r_i_v,
  input  logic             r_i_defl,
  input  logic [A_W-1:0]   r_i_addr,
  input  logic [D_W-1:0]   r_i_data,
  input  logic             u0_i_v,
  input  logic             u0_i_defl,
  input  logic [A_W-1:0]   u0_i_addr,
  input  logic [D_W-1:0]   u0_i_data,
  input  logic             u1_i_v,
  input  logic             u1_i_defl,
  input  logic [A_W-1:0]   u1_i_addr,
  input  logic [D_W-1:0]   u1_i_data,
  output logic             l_o_v,
  output logic             l_o_defl,
  output logic [A_W-1:0]   l_o_addr,
  output logic [D_W-1:0]   l_o_data,
  output logic             r_o_v,
  output logic             r_o_defl,
  output logic [A_W-1:0]   r_o_addr,
  output logic [D_W-1:0]   r_o_data,
  output logic             u0_o_v,
  output logic             u0_o_defl,
  output logic [A_W-1:0]   u0_o_addr,
  output logic [D_W-1:0]   u0_o_data,
  output logic             u1_o_v,
  output logic             u1_o_defl,
  output logic [A_W-1:0]   u1_o_addr,
  output logic [D_W-1:0]   u1_o_data,
  output logic [CNT_W-1:0] defl_cnt
);

  localparam logic [A_W-1:0]   POSX    = A_W'(posx);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Port index order: L=0, R=1, U0=2, U1=3
  logic [3:0]     in_v, in_defl;
  logic [A_W-1:0] in_addr [4];
  logic [D_W-1:0] in_data [4];

  assign in_v    = {u1_i_v, u0_i_v, r_i_v, l_i_v};
  assign in_defl = {u1_i_defl, u0_i_defl, r_i_defl, l_i_defl};
  assign in_addr[0] = l_i_addr;
  assign in_addr[1] = r_i_addr;
  assign in_addr[2] = u0_i_addr;
  assign in_addr[3] = u1_i_addr;
  assign in_data[0] = l_i_data;
  assign in_data[1] = r_i_data;
  assign in_data[2] = u0_i_data;
  assign in_data[3] = u1_i_data;

  logic [1:0]     rr_ptr;
  logic [3:0]     o_v_q, o_defl_q;
  logic [A_W-1:0] o_addr_q [4];
  logic [D_W-1:0] o_data_q [4];

  // Preferred/alternate output per input. Down-bound packets pick L or R
  // by the address bit at this level. Packets from below whose destination
  // is outside this subtree go up, with the other up port as a fallback.
  logic [1:0] pref [4];
  logic [1:0] alt  [4];
  logic [3:0] has_alt;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pref[i]    = in_addr[i][posl] ? 2'd1 : 2'd0;
      alt[i]     = 2'd0;
      has_alt[i] = 1'b0;
      if (i < 2 && ((in_addr[i] >> (posl + 1)) != POSX)) begin
        pref[i]    = (i == 0) ? 2'd2 : 2'd3;
        alt[i]     = (i == 0) ? 2'd3 : 2'd2;
        has_alt[i] = 1'b1;
      end
    end
  end

  // Greedy allocation. The first pass serves inputs that were already
  // deflected upstream and the second pass serves the rest. Both passes walk
  // the inputs starting at rr_ptr. Because there are as many outputs as
  // inputs, the last-resort scan always finds a free port. That scan may be
  // a U-turn.
  logic [3:0] busy, asg_v, asg_defl;
  logic [1:0] owner [4];
  logic [2:0] n_defl;
  logic [1:0] idx, dest;
  logic       placed;

  always_comb begin
    busy     = '0;
    asg_v    = '0;
    asg_defl = '0;
    n_defl   = '0;
    idx      = '0;
    dest     = '0;
    placed   = 1'b0;
    for (int j = 0; j < 4; j++) owner[j] = '0;
    for (int g = 0; g < 2; g++) begin
      for (int k = 0; k < 4; k++) begin
        idx = rr_ptr + 2'(k);
        if (in_v[idx] && (in_defl[idx] == (g == 0))) begin
          placed = 1'b0;
          dest   = '0;
          if (!busy[pref[idx]]) begin
            dest   = pref[idx];
            placed = 1'b1;
          end else if (has_alt[idx] && !busy[alt[idx]]) begin
            dest   = alt[idx];
            placed = 1'b1;
          end
          if (!placed) begin
            for (int j = 3; j >= 0; j--) begin
              if (!busy[j]) dest = 2'(j);
            end
            asg_defl[dest] = 1'b1;
            n_defl         = n_defl + 3'd1;
          end
          busy[dest]  = 1'b1;
          asg_v[dest] = 1'b1;
          owner[dest] = idx;
        end
      end
    end
  end

  // The sum is kept three bits wider than the counter. This lets a cycle
  // with up to four deflections clamp exactly at the maximum.
  logic [CNT_W+2:0] cnt_sum;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_sum  = {3'b000, defl_cnt} + (CNT_W + 3)'(n_defl);
    cnt_next = (cnt_sum > {3'b000, CNT_MAX}) ? CNT_MAX : cnt_sum[CNT_W-1:0];
  end

  // Output registers. Unassigned outputs drop valid but keep their last
  // address/payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_v_q    <= '0;
      o_defl_q <= '0;
      rr_ptr   <= '0;
      defl_cnt <= '0;
      for (int j = 0; j < 4; j++) begin
        o_addr_q[j] <= '0;
        o_data_q[j] <= '0;
      end
    end else if (ce) begin
      o_v_q    <= asg_v;
      o_defl_q <= asg_defl;
      defl_cnt <= cnt_next;
      if (|in_v) rr_ptr <= rr_ptr + 2'd1;
      for (int j = 0; j < 4; j++) begin
        if (asg_v[j]) begin
          o_addr_q[j] <= in_addr[owner[j]];
          o_data_q[j] <= in_data[owner[j]];
        end
      end
    end
  end

  assign {u1_o_v, u0_o_v, r_o_v, l_o_v}         = o_v_q;
  assign {u1_o_defl, u0_o_defl, r_o_defl, l_o_defl} = o_defl_q;
  assign l_o_addr  = o_addr_q[0];
  assign r_o_addr  = o_addr_q[1];
  assign u0_o_addr = o_addr_q[2];
  assign u1_o_addr = o_addr_q[3];
  assign l_o_data  = o_data_q[0];
  assign r_o_data  = o_data_q[1];
  assign u0_o_data = o_data_q[2];
  assign u1_o_data = o_data_q[3];

endmodule

// File: tb/tb_pi_route_defl.sv
// tb_pi_route_defl
// Self-checking bench for pi_route_defl at N=8, A_W=4, posl=0, posx=1.
// A second instance with CNT_W=2 shares the same inputs. It exercises the
// counter clamp.
module tb_pi_route_defl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b0;

  logic [3:0]       iv, idf;
  logic [3:0][3:0]  ia;
  logic [3:0][31:0] id;

  wire  [3:0]       ov, odf, ov_s, odf_s;
  wire  [3:0][3:0]  oa, oa_s;
  wire  [3:0][31:0] od, od_s;
  wire  [15:0]      cnt;
  wire  [1:0]       cnt_s;

  typedef struct packed {
    logic [3:0]       v;
    logic [3:0]       defl;
    logic [3:0][3:0]  addr;
    logic [3:0][31:0] data;
    logic [15:0]      cnt;
    logic [1:0]       cnt2;
  } exp_t;

  exp_t sb [$];
  exp_t m_prev;
  int   m_rr, m_cnt, m_cnt2;
  int   checks = 0;
  int   errors = 0;

  logic [3:0][3:0]  a;
  logic [3:0][31:0] d;
  logic [3:0]       rv, rdf;

  always #5 clk = ~clk;

  pi_route_defl #(.N(8), .A_W(4), .D_W(32), .posl(0), .posx(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .ce(ce),
    .l_i_v(iv[0]),  .l_i_defl(idf[0]),  .l_i_addr(ia[0]),  .l_i_data(id[0]),
    .r_i_v(iv[1]),  .r_i_defl(idf[1]),  .r_i_addr(ia[1]),  .r_i_data(id[1]),
    .u0_i_v(iv[2]), .u0_i_defl(idf[2]), .u0_i_addr(ia[2]), .u0_i_data(id[2]),
    .u1_i_v(iv[3]), .u1_i_defl(idf[3]), .u1_i_addr(ia[3]), .u1_i_data(id[3]),
    .l_o_v(ov[0]),  .l_o_defl(odf[0]),  .l_o_addr(oa[0]),  .l_o_data(od[0]),
    .r_o_v(ov[1]),  .r_o_defl(odf[1]),  .r_o_addr(oa[1]),  .r_o_data(od[1]),
    .u0_o_v(ov[2]), .u0_o_defl(odf[2]), .u0_o_addr(oa[2]), .u0_o_data(od[2]),
    .u1_o_v(ov[3]), .u1_o_defl(odf[3]), .u1_o_addr(oa[3]), .u1_o_data(od[3]),
    .defl_cnt(cnt)
  );

  pi_route_defl #(.N(8), .A_W(4), .D_W(32), .posl(0), .posx(1), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .ce(ce),
    .l_i_v(iv[0]),  .l_i_defl(idf[0]),  .l_i_addr(ia[0]),  .l_i_data(id[0]),
    .r_i_v(iv[1]),  .r_i_defl(idf[1]),  .r_i_addr(ia[1]),  .r_i_data(id[1]),
    .u0_i_v(iv[2]), .u0_i_defl(idf[2]), .u0_i_addr(ia[2]), .u0_i_data(id[2]),
    .u1_i_v(iv[3]), .u1_i_defl(idf[3]), .u1_i_addr(ia[3]), .u1_i_data(id[3]),
    .l_o_v(ov_s[0]),  .l_o_defl(odf_s[0]),  .l_o_addr(oa_s[0]),  .l_o_data(od_s[0]),
    .r_o_v(ov_s[1]),  .r_o_defl(odf_s[1]),  .r_o_addr(oa_s[1]),  .r_o_data(od_s[1]),
    .u0_o_v(ov_s[2]), .u0_o_defl(odf_s[2]), .u0_o_addr(oa_s[2]), .u0_o_data(od_s[2]),
    .u1_o_v(ov_s[3]), .u1_o_defl(odf_s[3]), .u1_o_addr(oa_s[3]), .u1_o_data(od_s[3]),
    .defl_cnt(cnt_s)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, want);
    end
  endtask

  // Reference router for posl=0, posx=1: local addresses are 2 and 3
  task automatic computeExpect(input logic [3:0] v, input logic [3:0] dfl,
                               input logic [3:0][3:0] ad, input logic [3:0][31:0] dt,
                               output exp_t e);
    logic [3:0] taken;
    int nd, i, pref, alt, dest;
    logic local_dst;
    e      = m_prev;
    e.v    = '0;
    e.defl = '0;
    taken  = '0;
    nd     = 0;
    for (int g = 1; g >= 0; g--) begin
      for (int k = 0; k < 4; k++) begin
        i = (m_rr + k) % 4;
        if (v[i] && (dfl[i] == (g == 1))) begin
          local_dst = (ad[i] == 4'd2) || (ad[i] == 4'd3);
          alt = -1;
          if (i >= 2 || local_dst) pref = ad[i][0] ? 1 : 0;
          else begin
            pref = (i == 0) ? 2 : 3;
            alt  = (i == 0) ? 3 : 2;
          end
          if (!taken[pref]) dest = pref;
          else if (alt >= 0 && !taken[alt]) dest = alt;
          else begin
            dest = 0;
            while (taken[dest]) dest++;
            e.defl[dest] = 1'b1;
            nd++;
          end
          taken[dest]  = 1'b1;
          e.v[dest]    = 1'b1;
          e.addr[dest] = ad[i];
          e.data[dest] = dt[i];
        end
      end
    end
    m_cnt  = (m_cnt + nd > 65535) ? 65535 : m_cnt + nd;
    m_cnt2 = (m_cnt2 + nd > 3) ? 3 : m_cnt2 + nd;
    if (|v) m_rr = (m_rr + 1) % 4;
    e.cnt  = 16'(m_cnt);
    e.cnt2 = 2'(m_cnt2);
    m_prev = e;
  endtask

  task automatic compareOutputs();
    exp_t e;
    if (sb.size() == 0) begin
      checkOutput("sb_empty", 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    for (int j = 0; j < 4; j++) begin
      checkOutput($sformatf("p%0d_v", j), 64'(ov[j]), 64'(e.v[j]));
      checkOutput($sformatf("p%0d_defl", j), 64'(odf[j]), 64'(e.defl[j]));
      checkOutput($sformatf("p%0d_addr", j), 64'(oa[j]), 64'(e.addr[j]));
      checkOutput($sformatf("p%0d_data", j), 64'(od[j]), 64'(e.data[j]));
    end
    checkOutput("defl_cnt", 64'(cnt), 64'(e.cnt));
    checkOutput("sat_cnt", 64'(cnt_s), 64'(e.cnt2));
    checkOutput("sat_v", 64'(ov_s), 64'(e.v));
    checkOutput("sat_defl", 64'(odf_s), 64'(e.defl));
    checkOutput("sat_data", 64'(od_s[0] ^ od_s[1] ^ od_s[2] ^ od_s[3]),
                64'(e.data[0] ^ e.data[1] ^ e.data[2] ^ e.data[3]));
  endtask

  task automatic applyStimulus(input logic ce_v, input logic [3:0] v, input logic [3:0] dfl,
                               input logic [3:0][3:0] ad, input logic [3:0][31:0] dt);
    exp_t e;
    @(negedge clk);
    rst = 1'b0;
    ce  = ce_v;
    iv  = v;
    idf = dfl;
    ia  = ad;
    id  = dt;
    if (ce_v) computeExpect(v, dfl, ad, dt, e);
    else e = m_prev;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compareOutputs();
  endtask

  // Two cycles of reset with random inputs and a random ce
  task automatic applyReset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      rst = 1'b1;
      ce  = 1'($urandom_range(0, 1));
      iv  = 4'($urandom);
      idf = 4'($urandom);
      ia  = 16'($urandom);
      id  = {$urandom, $urandom, $urandom, $urandom};
      sb.push_back('0);
      @(posedge clk);
      #1;
      compareOutputs();
    end
    m_prev = '0;
    m_rr   = 0;
    m_cnt  = 0;
    m_cnt2 = 0;
  endtask

  initial begin
    iv = '0; idf = '0; ia = '0; id = '0;
    m_prev = '0; m_rr = 0; m_cnt = 0; m_cnt2 = 0;

    // Right turn: L input to local address 3
    applyReset();
    a = '0; d = '0; a[0] = 4'd3; d[0] = 32'hA5;
    applyStimulus(1'b1, 4'b0001, 4'b0000, a, d);
    checkOutput("rturn_r_v", 64'(ov[1]), 64'd1);
    checkOutput("rturn_r_data", 64'(od[1]), 64'hA5);
    checkOutput("rturn_others", 64'({ov[3], ov[2], ov[0]}), 64'd0);

    // Two up-bound packets: no deflection
    applyReset();
    a = '0; d = '0; a[0] = 4'd5; a[1] = 4'd6; d[0] = 32'h11; d[1] = 32'h22;
    applyStimulus(1'b1, 4'b0011, 4'b0000, a, d);
    checkOutput("up_u0_data", 64'(od[2]), 64'h11);
    checkOutput("up_u1_data", 64'(od[3]), 64'h22);
    checkOutput("up_cnt", 64'(cnt), 64'd0);

    // Down conflict with rr_ptr=0, then a full load that crosses the clamp
    applyReset();
    a = '0; d = '0; a[2] = 4'd2; a[3] = 4'd2; d[2] = 32'd1; d[3] = 32'd2;
    applyStimulus(1'b1, 4'b1100, 4'b0000, a, d);
    checkOutput("conf_l_data", 64'(od[0]), 64'd1);
    checkOutput("conf_r_data", 64'(od[1]), 64'd2);
    checkOutput("conf_r_defl", 64'(odf[1]), 64'd1);
    checkOutput("conf_cnt", 64'(cnt), 64'd1);
    a = {4'd2, 4'd2, 4'd2, 4'd2}; d = {32'd13, 32'd12, 32'd11, 32'd10};
    applyStimulus(1'b1, 4'b1111, 4'b0000, a, d);
    checkOutput("cross_cnt", 64'(cnt), 64'd4);
    checkOutput("cross_sat", 64'(cnt_s), 64'd3);

    // Deflected packet wins the down conflict
    applyReset();
    a = '0; d = '0; a[2] = 4'd2; a[3] = 4'd2; d[2] = 32'd1; d[3] = 32'd2;
    applyStimulus(1'b1, 4'b1100, 4'b1000, a, d);
    checkOutput("dwin_l_data", 64'(od[0]), 64'd2);
    checkOutput("dwin_r_data", 64'(od[1]), 64'd1);
    checkOutput("dwin_r_defl", 64'(odf[1]), 64'd1);

    // Full load, ce hold, then repeated conflicts into saturation
    applyReset();
    a = {4'd2, 4'd2, 4'd2, 4'd2}; d = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    applyStimulus(1'b1, 4'b1111, 4'b0000, a, d);
    checkOutput("full_v", 64'(ov), 64'hF);
    checkOutput("full_cnt", 64'(cnt), 64'd3);
    for (int c = 0; c < 3; c++) applyStimulus(1'b0, 4'b1111, 4'b0000, a, d);
    checkOutput("hold_cnt", 64'(cnt), 64'd3);
    for (int c = 0; c < 3; c++) applyStimulus(1'b1, 4'b1111, 4'b0000, a, d);
    checkOutput("sat_stop", 64'(cnt_s), 64'd3);

    // Random traffic; inputs stay put across ce=0 cycles
    rv = '0; rdf = '0;
    for (int c = 0; c < 60; c++) begin
      if ($urandom_range(0, 4) != 0) begin
        rv  = 4'($urandom);
        rdf = 4'($urandom);
        a   = 16'($urandom);
        d   = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus(1'b1, rv, rdf, a, d);
      end else begin
        applyStimulus(1'b0, rv, rdf, a, d);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
